// File: rtl/ps2_rx_sequencer.sv
// PS/2 keyboard receiver: synchronizes PS2_CLK/PS2_DATA, frames 11-bit packets, folds E0/F0 prefixes
// into flags and queues {ext, break, code} in a small FIFO. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_rx_sequencer #(
    parameter int unsigned TIMEOUT_CYC     = 50000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;

    logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
    logic fall;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          tmo;
    logic          parity_ok;
    logic          frame_ok;
    logic          flag_ext, flag_brk;
    logic          wr_pend;
    logic [9:0]    wr_entry;

    logic [9:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       pop, full, do_wr;
    logic [9:0]                 head;

    // Clock synchronizer idles high so reset release cannot fake a falling edge
    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= PS2_DATA;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;
    assign tmo  = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = data_s2 & parity_ok;

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (tmo) begin
            state_nx = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s2) state_nx = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tcnt        <= '0;
            flag_ext    <= 1'b0;
            flag_brk    <= 1'b0;
            wr_pend     <= 1'b0;
            wr_entry    <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= tmo;
            wr_pend     <= 1'b0;
            if (state == IDLE || fall || tmo) tcnt <= '0;
            else                              tcnt <= tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit <= data_s2;
                    STOP: begin
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            flag_ext  <= 1'b0;
                            flag_brk  <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            flag_ext <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            flag_brk <= 1'b1;
                        end else begin
                            wr_pend  <= 1'b1;
                            wr_entry <= {flag_ext, flag_brk, shreg};
                            flag_ext <= 1'b0;
                            flag_brk <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop   = key_valid & key_ready;
    assign full  = (count == CW'(DEPTH));
    assign do_wr = wr_pend & (~full | pop);

    // A write into a full FIFO is still accepted when the head is popped in the same cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_pend & full & ~pop;
            if (do_wr) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head      = mem[rd_ptr];
        key_valid = (count != '0);
        key_code  = key_valid ? head[7:0] : '0;
        key_break = key_valid & head[8];
        key_ext   = key_valid & head[9];
    end

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Directed bench for ps2_rx_sequencer: table of single frames plus hand sequences for latency,
// timeout, overflow/wrap and mid-frame reset. Honors PS2_PARITY_CHECK_EN when defined.
module tb_ps2_rx_sequencer;

    localparam int HALF = 8;
    localparam int NV   = 12;

    logic       CLK = 1'b0;
    logic       reset, PS2_CLK, PS2_DATA, key_ready;
    logic       key_valid, key_break, key_ext, frame_err, timeout_err, overflow;
    logic [7:0] key_code;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_tmo = 0, n_ovf = 0;
    int f0, t0, o0;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_entry;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[NV];

    logic [7:0] drain_exp[4];

    ps2_rx_sequencer #(.TIMEOUT_CYC(64), .FIFO_DEPTH_LOG2(2)) dut (
        .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_break(key_break), .key_ext(key_ext), .frame_err(frame_err),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (frame_err)   n_ferr++;
        if (timeout_err) n_tmo++;
        if (overflow)    n_ovf++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // mode 1: pulse key_ready in the FIFO write cycle; mode 2: check key_valid latency
    task automatic send_bit(input logic b, input int mode);
        PS2_DATA = b;
        repeat (HALF) tick();
        PS2_CLK = 1'b0;
        if (mode == 1) begin
            repeat (3) tick();
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            repeat (HALF - 4) tick();
        end else if (mode == 2) begin
            repeat (3) tick();
            check("valid_before_write", key_valid, 0);
            tick();
            check("valid_after_write", key_valid, 1);
            repeat (HALF - 4) tick();
        end else begin
            repeat (HALF) tick();
        end
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int mode);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
        send_bit(bad_par ? ^d : ~^d, 0);
        send_bit(~bad_stop, mode);
        PS2_DATA = 1'b1;
        repeat (HALF) tick();
    endtask

    task automatic pop();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] code, input bit brk, input bit ext);
        check({tag, "_valid"}, key_valid, 1);
        check({tag, "_code"}, key_code, code);
        check({tag, "_brk"}, key_break, brk);
        check({tag, "_ext"}, key_ext, ext);
    endtask

    initial begin
        vecs[0]  = '{8'h16, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vecs[2]  = '{8'h16, 1'b0, 1'b0, 1'b1, 8'h16, 1'b1, 1'b0, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 0};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        vecs[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
`ifdef PS2_PARITY_CHECK_EN
        vecs[9]  = '{8'h1E, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
`else
        vecs[9]  = '{8'h1E, 1'b1, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 0};
`endif
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vecs[11] = '{8'h74, 1'b0, 1'b0, 1'b1, 8'h74, 1'b0, 1'b1, 0};

        reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; key_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_ovf", overflow, 0);

        // First frame: key_valid exactly two cycles after the stop edge is seen
        send_frame(8'h16, 1'b0, 1'b0, 2);
        expect_head("first", 8'h16, 1'b0, 1'b0);
        pop();
        check("first_popped", key_valid, 0);
        check("first_code_zero", key_code, 0);

        for (int i = 0; i < NV; i++) begin
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 0);
            check($sformatf("v%0d_valid", i), key_valid, vecs[i].exp_entry);
            check($sformatf("v%0d_code", i), key_code, vecs[i].exp_code);
            check($sformatf("v%0d_brk", i), key_break, vecs[i].exp_brk);
            check($sformatf("v%0d_ext", i), key_ext, vecs[i].exp_ext);
            check($sformatf("v%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_entry) begin
                pop();
                check($sformatf("v%0d_empty", i), key_valid, 0);
            end
        end
        check("no_spurious_tmo", n_tmo, 0);

        // Timeout mid-frame: start + 5 data bits, then silence
        f0 = n_ferr; t0 = n_tmo;
        send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        repeat (200) tick();
        check("tmo_pulse", n_tmo - t0, 1);
        check("tmo_no_ferr", n_ferr - f0, 0);
        check("tmo_fifo_empty", key_valid, 0);
        send_frame(8'h25, 1'b0, 1'b0, 0);
        expect_head("after_tmo", 8'h25, 1'b0, 1'b0);
        pop();

        // Overflow, then a full-FIFO write coinciding with a pop, then drain across pointer wrap
        o0 = n_ovf;
        send_frame(8'h16, 1'b0, 1'b0, 0);
        send_frame(8'h1E, 1'b0, 1'b0, 0);
        send_frame(8'h26, 1'b0, 1'b0, 0);
        send_frame(8'h25, 1'b0, 1'b0, 0);
        check("four_no_ovf", n_ovf - o0, 0);
        send_frame(8'h2E, 1'b0, 1'b0, 0);
        check("fifth_ovf", n_ovf - o0, 1);
        expect_head("ovf_head", 8'h16, 1'b0, 1'b0);
        send_frame(8'h36, 1'b0, 1'b0, 1);
        check("pop_write_no_ovf", n_ovf - o0, 1);
        drain_exp[0] = 8'h1E; drain_exp[1] = 8'h26; drain_exp[2] = 8'h25; drain_exp[3] = 8'h36;
        for (int i = 0; i < 4; i++) begin
            expect_head($sformatf("drain%0d", i), drain_exp[i], 1'b0, 1'b0);
            pop();
        end
        check("drained", key_valid, 0);

        // Reset in the middle of a frame with an entry queued
        f0 = n_ferr; t0 = n_tmo; o0 = n_ovf;
        send_frame(8'h16, 1'b0, 1'b0, 0);
        check("pre_rst_valid", key_valid, 1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        reset = 1'b1;
        tick();
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        tick();
        reset = 1'b0;
        repeat (150) tick();
        check("midrst_no_err", (n_ferr - f0) + (n_tmo - t0) + (n_ovf - o0), 0);
        check("midrst_still_empty", key_valid, 0);
        send_frame(8'h3D, 1'b0, 1'b0, 0);
        expect_head("after_rst", 8'h3D, 1'b0, 1'b0);
        pop();
        check("final_empty", key_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
